// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial word comparator: FSM state encoding
// and the bit-counter width helper.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 32'sd1);
    endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit compare cell: e = bits equal, g = x greater than y.
// Multi-output counterpart of the 1-bit equality primitive.
module bit_cmp_cell (
    input  logic x,
    input  logic y,
    output logic e,
    output logic g
);

    assign e = ~(x ^ y);
    assign g = x & ~y;

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial unsigned comparator. Collects WIDTH bit pairs of x/y and
// reports eq/gt/lt with a one-cycle done pulse. Results hold until the
// next accepted start.
module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic x,
    input  logic y,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          decided_r;
    logic          gt_r;
    logic          lt_r;

    logic          e_s;
    logic          g_s;
    logic          gt_next_s;
    logic          lt_next_s;
    logic          decided_next_s;

    bit_cmp_cell u_cell (
        .x (x),
        .y (y),
        .e (e_s),
        .g (g_s)
    );

    // Fold the current bit pair into the running decision: MSB-first keeps
    // the first difference, LSB-first lets the latest difference win.
    always_comb begin
        gt_next_s      = gt_r;
        lt_next_s      = lt_r;
        decided_next_s = decided_r;
        if (!e_s && (!MSB_FIRST || !decided_r)) begin
            gt_next_s      = g_s;
            lt_next_s      = ~g_s;
            decided_next_s = 1'b1;
        end else begin
            gt_next_s      = gt_r;
            lt_next_s      = lt_r;
            decided_next_s = decided_r;
        end
    end

    // Frame sequencing, bit counting, decision tracking and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            decided_r <= 1'b0;
            gt_r      <= 1'b0;
            lt_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= S_SHIFT;
                        cnt_r     <= CNT_ZERO;
                        decided_r <= 1'b0;
                        gt_r      <= 1'b0;
                        lt_r      <= 1'b0;
                        busy      <= 1'b1;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_valid) begin
                        cnt_r     <= cnt_r + CNT_ONE;
                        decided_r <= decided_next_s;
                        gt_r      <= gt_next_s;
                        lt_r      <= lt_next_s;
                        if (cnt_r == LAST_CNT) begin
                            state_r <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            eq      <= ~decided_next_s;
                            gt      <= gt_next_s;
                            lt      <= lt_next_s;
                        end else begin
                            state_r <= S_SHIFT;
                        end
                    end else begin
                        state_r <= S_SHIFT;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Scoreboard bench for serial_word_comparator: one MSB-first and one
// LSB-first instance; stimulus pushes expected results, monitors pop them.
module tb_serial_word_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic bit_valid;
    logic x;
    logic y;
    logic sel_lsb;

    logic start_m, bv_m, start_l, bv_l;
    assign start_m = start & ~sel_lsb;
    assign bv_m    = bit_valid & ~sel_lsb;
    assign start_l = start & sel_lsb;
    assign bv_l    = bit_valid & sel_lsb;

    logic busy_m, done_m, eq_m, gt_m, lt_m;
    logic busy_l, done_l, eq_l, gt_l, lt_l;

    serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start_m), .bit_valid(bv_m),
        .x(x), .y(y), .busy(busy_m), .done(done_m),
        .eq(eq_m), .gt(gt_m), .lt(lt_m)
    );

    serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start_l), .bit_valid(bv_l),
        .x(x), .y(y), .busy(busy_l), .done(done_l),
        .eq(eq_l), .gt(gt_l), .lt(lt_l)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cyc = 0;

    typedef struct {
        int         cyc;
        logic [2:0] res;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {busy, done, eq, gt, lt} of the currently selected instance
    function automatic logic [4:0] outs();
        return sel_lsb ? {busy_l, done_l, eq_l, gt_l, lt_l}
                       : {busy_m, done_m, eq_m, gt_m, lt_m};
    endfunction

    // MSB-first monitor
    always @(negedge clk) begin
        exp_t e;
        if (done_m === 1'b1) begin
            if (q_m.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL msb_unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = q_m.pop_front();
                check("msb_done_cycle", 64'(cyc), 64'(e.cyc));
                check("msb_result_eq_gt_lt", 64'({eq_m, gt_m, lt_m}), 64'(e.res));
                check("msb_busy_at_done", 64'(busy_m), 64'd0);
            end
        end
    end

    // LSB-first monitor
    always @(negedge clk) begin
        exp_t e;
        if (done_l === 1'b1) begin
            if (q_l.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lsb_unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e = q_l.pop_front();
                check("lsb_done_cycle", 64'(cyc), 64'(e.cyc));
                check("lsb_result_eq_gt_lt", 64'({eq_l, gt_l, lt_l}), 64'(e.res));
                check("lsb_busy_at_done", 64'(busy_l), 64'd0);
            end
        end
    end

    // Start pulse with a junk bit pair that must be ignored; called at a negedge.
    task automatic pulse_start();
        start     = 1'b1;
        bit_valid = 1'b1;
        x         = 1'b1;
        y         = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", 64'(outs()), 64'b10000);
    endtask

    // Send nbits bit pairs; gapped inserts 0/1/3 idle cycles; inject pulses start at bit 4.
    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int nbits,
                             input bit gapped, input bit inject, input logic [2:0] res);
        int   gaps[3] = '{0, 1, 3};
        int   total = 0;
        int   idx;
        int   g;
        exp_t e;
        if (nbits == 8) begin
            for (int i = 0; i < 8; i++) total += gapped ? gaps[i % 3] : 0;
            e.cyc = start_cyc + 8 + total;
            e.res = res;
            if (sel_lsb) q_l.push_back(e);
            else         q_m.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            g = gapped ? gaps[i % 3] : 0;
            repeat (g) @(negedge clk);
            check("busy_no_result_in_frame", 64'(outs()), 64'b10000);
            idx       = sel_lsb ? i : 7 - i;
            bit_valid = 1'b1;
            x         = a[idx];
            y         = b[idx];
            start     = inject && (i == 4);
            @(negedge clk);
            bit_valid = 1'b0;
            start     = 1'b0;
        end
    endtask

    // Results hold after done, with stray bit pairs outside a frame ignored.
    task automatic check_hold(input string name, input logic [2:0] res);
        bit_valid = 1'b1;
        x         = 1'b0;
        y         = 1'b1;
        repeat (2) @(negedge clk);
        bit_valid = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        check(name, 64'(outs()), 64'({2'b00, res}));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        sel_lsb   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_msb_outputs", 64'({busy_m, done_m, eq_m, gt_m, lt_m}), 64'd0);
        check("reset_lsb_outputs", 64'({busy_l, done_l, eq_l, gt_l, lt_l}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_msb_outputs", 64'({busy_m, done_m, eq_m, gt_m, lt_m}), 64'd0);

        // Equal operands, MSB-first
        pulse_start();
        send_bits(8'hA5, 8'hA5, 8, 1'b0, 1'b0, 3'b100);
        check_hold("hold_eq_a5", 3'b100);

        // MSB decides, later bits favour B
        pulse_start();
        send_bits(8'h80, 8'h7F, 8, 1'b0, 1'b0, 3'b010);
        check_hold("hold_gt_80_7f", 3'b010);

        // Gaps and an ignored start mid-frame
        pulse_start();
        send_bits(8'h3C, 8'h3D, 8, 1'b1, 1'b1, 3'b001);
        check_hold("hold_lt_3c_3d", 3'b001);

        // Asynchronous reset mid-frame
        pulse_start();
        send_bits(8'h55, 8'hAA, 5, 1'b0, 1'b0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({busy_m, done_m, eq_m, gt_m, lt_m}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 64'(outs()), 64'd0);
        pulse_start();
        send_bits(8'hFF, 8'h00, 8, 1'b0, 1'b0, 3'b010);
        check_hold("hold_gt_ff_00", 3'b010);

        // Back-to-back frames, second start in DONE
        pulse_start();
        send_bits(8'h12, 8'h12, 8, 1'b0, 1'b0, 3'b100);
        pulse_start();
        send_bits(8'h40, 8'h41, 8, 1'b0, 1'b0, 3'b001);
        check_hold("hold_lt_40_41", 3'b001);

        // LSB-first: last differing bit (bit 7) decides
        sel_lsb = 1'b1;
        @(negedge clk);
        pulse_start();
        send_bits(8'h01, 8'h80, 8, 1'b0, 1'b0, 3'b001);
        check_hold("hold_lsb_lt_01_80", 3'b001);
        pulse_start();
        send_bits(8'hC3, 8'hC3, 8, 1'b0, 1'b0, 3'b100);
        check_hold("hold_lsb_eq_c3", 3'b100);

        repeat (3) @(negedge clk);
        check("msb_missing_done", 64'(q_m.size()), 64'd0);
        check("lsb_missing_done", 64'(q_l.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
